timebase_generator: RTL
=======================

Name: timebase_generator

Overview:
- Downstream consumer of the clock_management outputs. Runs on clk_f100_p0 with rstb_f100_p0 and is the design's common time reference.
- A prescaler produces a one-cycle base tick strobe at TICK_FREQUENCY.
- A programmable one-shot/periodic countdown timer counts those ticks and reports busy/done.
- A heartbeat output toggles at a fixed rate for liveness indication.

Parameters:
- CLK_FREQUENCY, 100_000_000, input clock frequency in Hz. Instantiated with MASTER_CLOCK_FREQUENCY-derived f100 value.
- TICK_FREQUENCY, 1_000, base tick rate in Hz. DIV = CLK_FREQUENCY/TICK_FREQUENCY must be an integer >= 2. Any other value is an elaboration error.
- TIMER_WIDTH, 16, width of the timer load and count.
- HEARTBEAT_TICKS, 500, number of base ticks between heartbeat toggles. Must be >= 1.

Ports:
- clk  input  1  system clock (connected to clk_f100_p0).
- rstb  input  1  asynchronous active-low reset (connected to rstb_f100_p0).
- en  input  1  prescaler enable. Low freezes the prescaler, so no ticks are produced.
- tick_base  output  1  one-cycle strobe every DIV cycles while en is high.
- timer_load  input  TIMER_WIDTH  tick count, sampled only in the cycle timer_start is high.
- timer_mode  input  1  0 = one-shot, 1 = periodic. Sampled with timer_start.
- timer_start  input  1  single-cycle start/retrigger request.
- timer_stop  input  1  single-cycle abort request.
- timer_busy  output  1  high while the timer is in RUN.
- timer_done  output  1  one-cycle pulse on expiry.
- heartbeat  output  1  square wave toggling every HEARTBEAT_TICKS ticks.

Behaviour:
- Reset (rstb low, asynchronous) clears every output to 0. It also clears the prescaler count, the timer state (to IDLE), the timer count, the latched load/mode, and the heartbeat count.
- Synchronous operation starts on the first rising clk edge after rstb deasserts.
- Prescaler count runs 0..DIV-1 and increments only while en is high.
- At DIV-1 the count wraps to 0 and tick_base is registered high for exactly the next cycle.
- With en held high, tick_base pulses exactly every DIV cycles. The first pulse occurs DIV cycles after the first enabled edge.
- When en is low the count holds its value and tick_base stays 0. Re-asserting en resumes from the held count; there is no restart.
- Timer FSM has two states, IDLE and RUN. Transitions are evaluated each cycle in this priority order:
  - timer_stop: go to IDLE, no done pulse, count cleared. Stop wins over a simultaneous start or expiry.
  - timer_start with timer_load == 0: go to IDLE and pulse timer_done in the next cycle.
  - timer_start with timer_load != 0 (from IDLE or RUN): latch load and mode, set count to load, go to RUN. timer_busy is high from the next cycle. A start in RUN is a retrigger; the old count is discarded with no done pulse.
  - In RUN, when tick_base is high the count decrements by 1.
  - Expiry is a tick_base seen while count == 1. On expiry timer_done pulses in the next cycle.
    - One-shot: go to IDLE; busy drops in the same cycle done rises.
    - Periodic: reload the count from the latched load value and stay in RUN; busy stays high.
- Timing: the timer counts the first tick_base strictly after the start cycle. Elapsed time from start to done is therefore (load-1)*DIV+1 to load*DIV cycles, plus 1 cycle of registered output.
- A tick_base coincident with the start cycle is not counted.
- If en is low the timer stalls in RUN indefinitely; this is legal.
- Heartbeat counter counts tick_base pulses from 0 to HEARTBEAT_TICKS-1. On wrap it toggles heartbeat; the toggle is registered and visible in the cycle after the wrapping tick.
- The heartbeat counter is independent of the timer and of timer_stop.
- Reset asserted mid-operation aborts immediately and asynchronously to the reset state. No done pulse is produced.
- Width rules:
  - Prescaler width = $clog2(DIV).
  - Heartbeat counter width = $clog2(HEARTBEAT_TICKS), minimum 1.
  - Timer arithmetic is unsigned TIMER_WIDTH. Count never underflows because expiry is detected at 1.

Decomposition:
- DIV and the counter-width localparams are derived in the shared CLOCK_MANAGEMENT_PARAMETER.vh header, next to the f100/f10 frequency constants.
- The FSM state encodings (TIMER_IDLE = 1'b0, TIMER_RUN = 1'b1) also go in that header.
- One sub-module, tick_prescaler:
  - Parameter DIV.
  - Ports clk, rstb, en, tick.
  - Also reusable on the f10 domain.
- Timer FSM and heartbeat stay in the top module.

Test Plan:
All scenarios use CLK_FREQUENCY=100_000_000, TICK_FREQUENCY=1_000_000 (DIV=100), TIMER_WIDTH=16, HEARTBEAT_TICKS=5.
- Reset/prescaler: release rstb with en=1 -> all outputs 0 during reset. tick_base first high 100 cycles after the first enabled edge, then every 100 cycles, always exactly 1 cycle wide. Drop en for 37 cycles mid-period -> next tick delayed by exactly 37 cycles.
- One-shot: start, load=3, mode=0 -> busy from the next cycle. done pulses once, 1 cycle after the 3rd tick following start. busy falls with done; no further done pulses.
- Periodic and stop: start, load=2, mode=1 -> done every 200 cycles, busy stays high. Assert stop and start in the same cycle -> IDLE, busy 0, no done.
- Retrigger and zero load:
  - Start load=4, then start load=2 after 1 tick -> done 1 cycle after the 2nd tick following the retrigger; only one done pulse total.
  - Start load=0 -> done in the next cycle, busy stays 0.
- Heartbeat: run 20 ticks -> heartbeat toggles every 500 cycles (5 ticks), giving a 0,1,0,1 pattern.
- Reset mid-operation: assert rstb low mid-count -> busy, done and heartbeat drop to 0 immediately, with no done pulse after release.

Source files
------------

// File: rtl/timebase_generator_pkg.sv
// -----------------------------------------------------------------------------
// timebase_generator_pkg
// Shared definitions for the timebase generator and its tick prescaler:
//   - timer_state_t : timer FSM state encoding (TIMER_IDLE = 0, TIMER_RUN = 1)
//   - cnt_width()   : width of a counter that runs 0..n-1, never less than 1 bit
// -----------------------------------------------------------------------------
package timebase_generator_pkg;

   typedef enum logic {
      TIMER_IDLE = 1'b0,
      TIMER_RUN  = 1'b1
   } timer_state_t;

   // A modulo-n counter needs $clog2(n) bits; a single-state counter still
   // needs one bit so the register declaration stays legal.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/timebase_generator_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk by DIV and emits a one-cycle tick strobe. The count only moves
// while en is high, so dropping en freezes the phase and raising it again
// resumes from where it stopped.
// Ports:
//   clk   in   system clock
//   rstb  in   asynchronous active-low reset
//   en    in   count enable
//   tick  out  registered one-cycle strobe, once every DIV enabled cycles
// -----------------------------------------------------------------------------
module tick_prescaler
   import timebase_generator_pkg::*;
#(
   parameter int DIV = 100
) (
   input  logic clk,
   input  logic rstb,
   input  logic en,
   output logic tick
);

   localparam int            CW   = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         count_reg <= '0;
         tick      <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (en) begin
            if (count_reg == LAST) begin
               count_reg <= '0;
               tick      <= 1'b1;
            end else begin
               count_reg <= count_reg + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/timebase_generator.sv
// -----------------------------------------------------------------------------
// timebase_generator
// Common time reference: a base tick prescaler, a one-shot/periodic countdown
// timer clocked by the base ticks, and a heartbeat square wave.
// Ports:
//   clk          in   system clock
//   rstb         in   asynchronous active-low reset
//   en           in   prescaler enable (low freezes the tick phase)
//   tick_base    out  one-cycle strobe every DIV enabled cycles
//   timer_load   in   tick count, sampled with timer_start
//   timer_mode   in   0 = one-shot, 1 = periodic, sampled with timer_start
//   timer_start  in   start / retrigger request
//   timer_stop   in   abort request (wins over start and expiry)
//   timer_busy   out  high while the timer is running
//   timer_done   out  one-cycle pulse on expiry
//   heartbeat    out  toggles every HEARTBEAT_TICKS base ticks
// -----------------------------------------------------------------------------
module timebase_generator
   import timebase_generator_pkg::*;
#(
   parameter int CLK_FREQUENCY   = 100_000_000,
   parameter int TICK_FREQUENCY  = 1_000,
   parameter int TIMER_WIDTH     = 16,
   parameter int HEARTBEAT_TICKS = 500
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   en,
   output logic                   tick_base,
   input  logic [TIMER_WIDTH-1:0] timer_load,
   input  logic                   timer_mode,
   input  logic                   timer_start,
   input  logic                   timer_stop,
   output logic                   timer_busy,
   output logic                   timer_done,
   output logic                   heartbeat
);

   localparam int DIV  = (TICK_FREQUENCY > 0) ? CLK_FREQUENCY / TICK_FREQUENCY : 0;
   localparam int HB_W = cnt_width(HEARTBEAT_TICKS);
   localparam logic [HB_W-1:0]        HB_LAST = HB_W'(HEARTBEAT_TICKS - 1);
   localparam logic [TIMER_WIDTH-1:0] T_ONE   = TIMER_WIDTH'(1);

   // Reject frequency pairs that do not divide to an integer ratio of at
   // least two, and heartbeat periods shorter than one tick.
   if (TICK_FREQUENCY <= 0 || DIV < 2 || DIV * TICK_FREQUENCY != CLK_FREQUENCY) begin : g_bad_div
      $error("timebase_generator: CLK_FREQUENCY/TICK_FREQUENCY must be an integer >= 2");
   end
   if (HEARTBEAT_TICKS < 1) begin : g_bad_hb
      $error("timebase_generator: HEARTBEAT_TICKS must be >= 1");
   end

   // ---------------------------------------------------------------- prescaler
   tick_prescaler #(
      .DIV (DIV)
   ) u_tick_prescaler (
      .clk  (clk),
      .rstb (rstb),
      .en   (en),
      .tick (tick_base)
   );

   // ---------------------------------------------------------------- timer FSM
   timer_state_t           state_reg, state_next;
   logic [TIMER_WIDTH-1:0] count_reg, count_next;
   logic [TIMER_WIDTH-1:0] load_reg,  load_next;
   logic                   mode_reg,  mode_next;
   logic                   done_reg,  done_next;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_reg <= TIMER_IDLE;
         count_reg <= '0;
         load_reg  <= '0;
         mode_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         load_reg  <= load_next;
         mode_reg  <= mode_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      load_next  = load_reg;
      mode_next  = mode_reg;
      done_next  = 1'b0;

      if (timer_stop) begin
         state_next = TIMER_IDLE;
         count_next = '0;
      end else if (timer_start) begin
         // A start always takes precedence over a tick in the same cycle, so
         // a coincident tick is never counted against the new load.
         if (timer_load == '0) begin
            state_next = TIMER_IDLE;
            count_next = '0;
            done_next  = 1'b1;
         end else begin
            state_next = TIMER_RUN;
            count_next = timer_load;
            load_next  = timer_load;
            mode_next  = timer_mode;
         end
      end else if (state_reg == TIMER_RUN && tick_base) begin
         // Expiry is caught at 1 rather than 0 so the count never wraps.
         if (count_reg == T_ONE) begin
            done_next = 1'b1;
            if (mode_reg) begin
               count_next = load_reg;
            end else begin
               state_next = TIMER_IDLE;
               count_next = '0;
            end
         end else begin
            count_next = count_reg - T_ONE;
         end
      end
   end

   assign timer_busy = (state_reg == TIMER_RUN);
   assign timer_done = done_reg;

   // ---------------------------------------------------------------- heartbeat
   logic [HB_W-1:0] hb_count_reg;
   logic            heartbeat_reg;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         hb_count_reg  <= '0;
         heartbeat_reg <= 1'b0;
      end else if (tick_base) begin
         if (hb_count_reg == HB_LAST) begin
            hb_count_reg  <= '0;
            heartbeat_reg <= ~heartbeat_reg;
         end else begin
            hb_count_reg <= hb_count_reg + HB_W'(1);
         end
      end
   end

   assign heartbeat = heartbeat_reg;

endmodule
